// File: rtl/gameport_pkg.sv
// Shared definitions for the ao486 gameport scheduler: applied-mode encoding,
// default GrIP timing constants, and the mode-request normaliser.
package gameport_pkg;

   typedef enum logic [1:0] {
      MODE_2JOY   = 2'd0,
      MODE_4BTN   = 2'd1,
      MODE_GRAVIS = 2'd2
   } mode_e;

   localparam int HALF_DIV_DEFAULT   = 2262;
   localparam int FRAME_BITS_DEFAULT = 24;

   // Encoding 3 is reserved and folds onto the two-joystick mode.
   function automatic mode_e norm_mode(input logic [1:0] cfg);
      case (cfg)
         2'd1:    return MODE_4BTN;
         2'd2:    return MODE_GRAVIS;
         default: return MODE_2JOY;
      endcase
   endfunction

endpackage

// File: rtl/gameport_scheduler_if.sv
// CPU-side I/O bus of the gameport at 0x201: decoder select, strobes, read return.
interface gameport_scheduler_if;
   logic       io_cs;
   logic       io_read;
   logic       io_write;
   logic [7:0] io_readdata;
   logic       io_read_valid;

   modport master (
      output io_cs, io_read, io_write,
      input  io_readdata, io_read_valid
   );

   modport slave (
      input  io_cs, io_read, io_write,
      output io_readdata, io_read_valid
   );
endinterface

// File: rtl/gameport_strobe_edge.sv
// Registered rising-edge one-shot: a strobe held for any number of cycles yields
// one pulse, visible in the cycle after the strobe first rises.
module gameport_strobe_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic i_strobe,
   output logic o_rise,
   output logic o_pulse
);
   logic r_act;
   logic r_pulse;

   assign o_rise  = i_strobe & ~r_act;
   assign o_pulse = r_pulse;

   // Track the strobe level and launch the pulse on its rising edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_act   <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_act   <= i_strobe;
         r_pulse <= o_rise;
      end
   end
endmodule

// File: rtl/gameport_scheduler.sv
// Gameport sequencing controller: one-shot CPU strobes, GrIP bit clock, per-frame
// pad snapshots and frame-aligned mode changes for the gameport datapath.
module gameport_scheduler
   import gameport_pkg::*;
#(
   parameter int HALF_DIV   = HALF_DIV_DEFAULT,
   parameter int FRAME_BITS = FRAME_BITS_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   gameport_scheduler_if.slave  io_bus,
   input  logic [7:0]           i_joy_readdata,
   output logic                 o_joy_write,
   input  logic [13:0]          i_dig_1_in,
   input  logic [13:0]          i_dig_2_in,
   input  logic [1:0]           i_mode_cfg,
   output logic [13:0]          o_dig_1,
   output logic [13:0]          o_dig_2,
   output logic [1:0]           o_mode,
   output logic                 o_clk_grav,
   output logic                 o_frame_start
);
   localparam int DIV_W  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam int EDGE_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(FRAME_BITS - 1);

   logic              w_wr_strobe;
   logic              w_rd_strobe;
   logic              w_wr_rise_unused;
   logic              w_rd_rise;
   logic              w_rd_pulse;
   logic              w_wr_pulse;
   mode_e             w_cfg;
   logic              w_div_wrap;
   logic              w_rise;
   logic              w_frame_start;
   logic              w_boundary;

   logic [7:0]        r_readdata;
   mode_e             r_mode;
   logic [DIV_W-1:0]  r_div;
   logic [EDGE_W-1:0] r_edge;
   logic              r_clk_grav;
   logic              r_frame_start;
   logic [13:0]       r_dig_1;
   logic [13:0]       r_dig_2;

   assign w_wr_strobe = io_bus.io_cs & io_bus.io_write;
   assign w_rd_strobe = io_bus.io_cs & io_bus.io_read;

   gameport_strobe_edge u_wr_edge (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_strobe (w_wr_strobe),
      .o_rise   (w_wr_rise_unused),
      .o_pulse  (w_wr_pulse)
   );

   gameport_strobe_edge u_rd_edge (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_strobe (w_rd_strobe),
      .o_rise   (w_rd_rise),
      .o_pulse  (w_rd_pulse)
   );

   assign w_cfg         = norm_mode(i_mode_cfg);
   assign w_div_wrap    = (r_div == DIV_LAST);
   assign w_rise        = w_div_wrap & ~r_clk_grav;
   assign w_frame_start = w_rise & (r_edge == {EDGE_W{1'b0}});
   // The boundary is the falling toggle once the edge counter has wrapped back to 0.
   assign w_boundary    = w_div_wrap & r_clk_grav & (r_edge == {EDGE_W{1'b0}});

   // Capture the datapath status byte on each read rising edge; hold otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_readdata <= 8'd0;
      end else if (w_rd_rise) begin
         r_readdata <= i_joy_readdata;
      end else begin
         r_readdata <= r_readdata;
      end
   end

   // Mode register, GrIP divider/edge counter and pad-state scheduling.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mode        <= MODE_2JOY;
         r_div         <= {DIV_W{1'b0}};
         r_edge        <= {EDGE_W{1'b0}};
         r_clk_grav    <= 1'b0;
         r_frame_start <= 1'b0;
         r_dig_1       <= 14'd0;
         r_dig_2       <= 14'd0;
      end else begin
         r_frame_start <= 1'b0;
         if (r_mode != MODE_GRAVIS) begin
            // Non-Gravis modes follow the request at once; this also covers Gravis entry.
            r_mode     <= w_cfg;
            r_div      <= {DIV_W{1'b0}};
            r_edge     <= {EDGE_W{1'b0}};
            r_clk_grav <= 1'b0;
            r_dig_1    <= i_dig_1_in;
            r_dig_2    <= i_dig_2_in;
         end else if (w_boundary && (w_cfg != MODE_GRAVIS)) begin
            r_mode     <= w_cfg;
            r_div      <= {DIV_W{1'b0}};
            r_edge     <= {EDGE_W{1'b0}};
            r_clk_grav <= 1'b0;
         end else begin
            r_div      <= w_div_wrap ? {DIV_W{1'b0}} : (r_div + DIV_W'(1));
            r_clk_grav <= w_div_wrap ? ~r_clk_grav : r_clk_grav;
            if (w_rise) begin
               r_edge <= (r_edge == EDGE_LAST) ? {EDGE_W{1'b0}} : (r_edge + EDGE_W'(1));
            end else begin
               r_edge <= r_edge;
            end
            if (w_frame_start) begin
               r_frame_start <= 1'b1;
               r_dig_1       <= i_dig_1_in;
               r_dig_2       <= i_dig_2_in;
            end else begin
               r_dig_1       <= r_dig_1;
               r_dig_2       <= r_dig_2;
            end
         end
      end
   end

   assign io_bus.io_readdata   = r_readdata;
   assign io_bus.io_read_valid = w_rd_pulse;
   assign o_joy_write          = w_wr_pulse;
   assign o_dig_1              = r_dig_1;
   assign o_dig_2              = r_dig_2;
   assign o_mode               = r_mode;
   assign o_clk_grav           = r_clk_grav;
   assign o_frame_start        = r_frame_start;
endmodule

// File: doc/gameport_scheduler.md
Name: gameport_scheduler

Overview:
- Sequencing controller in front of the ao486 SoC gameport datapath at I/O 0x201.
- Converts CPU I/O strobes into single-cycle trigger and read pulses.
- Generates the 20 kHz Gravis GrIP bit clock and snapshots the digital pad state once per 24-bit frame, so a frame never mixes two pad states.
- Owns the mode register and defers mode changes to frame boundaries, so the datapath's internal bit counter stays frame-aligned.

Parameters:
HALF_DIV, 2262, clk cycles per half-period of clk_grav (90.5 MHz / 2262 / 2 ≈ 20 kHz).
FRAME_BITS, 24, clk_grav rising edges per GrIP frame.

Ports:
clk  in  1  system clock (90.5 MHz)
rst_n  in  1  reset, synchronous, active-low
io_cs  in  1  address-decoder select for the gameport
io_read  in  1  CPU read strobe (may be multi-cycle)
io_write  in  1  CPU write strobe (may be multi-cycle)
io_readdata  out  8  data returned to the CPU
io_read_valid  out  1  one-cycle pulse; io_readdata valid
joy_readdata  in  8  registered status byte from the gameport datapath
joy_write  out  1  one-cycle one-shot trigger to the datapath
dig_1_in  in  14  player-1 digital buttons, clk domain
dig_2_in  in  14  player-2 digital buttons, clk domain
mode_cfg  in  2  requested mode: 0 = 2×2-button, 1 = 1×4-button, 2 = Gravis; 3 is treated as 0
dig_1  out  14  scheduled player-1 state to the datapath
dig_2  out  14  scheduled player-2 state to the datapath
mode  out  2  applied mode to the datapath
clk_grav  out  1  GrIP bit clock to the datapath
frame_start  out  1  one-cycle pulse at each frame-start rising edge

Behaviour:
- Reset values: io_readdata=0, io_read_valid=0, joy_write=0, dig_1=dig_2=0, mode=0, clk_grav=0, frame_start=0.
- Reset clears all internal counters. Reset mid-frame aborts the frame; the datapath resets on the same rst_n, so alignment is preserved.
- Write path:
  - wr_act = io_cs & io_write, registered.
  - joy_write pulses for exactly 1 cycle on the cycle after the wr_act rising edge.
  - A held strobe produces one pulse. Back-to-back strobes with at least one low cycle between them produce one pulse each.
- Read path:
  - rd_act = io_cs & io_read, edge-detected the same way.
  - On the cycle after the rising edge, io_readdata <= joy_readdata and io_read_valid=1 for 1 cycle.
  - io_readdata holds between reads.
  - A read and a write rising in the same cycle are both serviced; joy_write and io_read_valid assert together.
- Mode register:
  - mode_cfg is sampled every cycle.
  - Entering Gravis (mode≠2, mode_cfg=2): apply next cycle. Divider and edge counter are cleared and clk_grav starts low.
  - Change between 0 and 1: apply next cycle.
  - Leaving Gravis (mode=2, mode_cfg≠2): deferred to the frame boundary (defined below), then applied. clk_grav is held low afterwards.
  - If mode_cfg returns to 2 before the boundary, the pending exit is cancelled.
- Gravis timing, mode=2 only:
  - Divider div counts 0..HALF_DIV-1. At div=HALF_DIV-1, div wraps to 0 and clk_grav toggles.
  - Edge counter edge counts 0..FRAME_BITS-1. It increments, with wrap, on each low→high toggle of clk_grav.
  - Frame-start rising edge = the low→high toggle while edge=0. frame_start pulses in that cycle.
  - Frame boundary = the high→low toggle while edge=0, i.e. after FRAME_BITS rising edges. No boundary occurs before the first frame's rising edges complete.
  - In modes 0/1: div=0, edge=0, clk_grav=0.
- Digital scheduling:
  - Modes 0/1: dig_x <= dig_x_in every cycle (1-cycle latency).
  - Mode 2: dig_x <= dig_x_in only in the frame_start cycle; otherwise held.
  - On Gravis entry, dig_x is also captured in the entry cycle.

Decomposition:
- Shared package (gameport_pkg): mode constants MODE_2JOY=0, MODE_4BTN=1, MODE_GRAVIS=2; default HALF_DIV and FRAME_BITS.
- One natural sub-module: gameport_strobe_edge, a registered rising-edge one-shot. Instantiate it twice, for read and for write.

Test Plan:
- Reset, write strobe: HALF_DIV=4. Hold rst_n=0 for 3 cycles, then io_cs=io_write=1 for 5 cycles → all outputs 0 during reset; exactly one joy_write pulse, 1 cycle after the strobe rises.
- Read capture: joy_readdata=8'hA5, then a 3-cycle read strobe → io_read_valid pulses once, 1 cycle after the strobe rises, with io_readdata=8'hA5. Then set joy_readdata=8'h3C with no read → io_readdata stays 8'hA5.
- Gravis clock: mode_cfg=2, HALF_DIV=4 →
  - clk_grav period 8 cycles, 50% duty.
  - frame_start every 24×8=192 cycles.
  - dig_1_in changed mid-frame (0x0001→0x2000) → dig_1 changes only at the next frame_start.
- Deferred exit: mode_cfg 2→0 at rising edge 10 → mode stays 2 until the falling edge after rising edge 24, then mode=0 and clk_grav=0. Re-entry then starts at edge 0.
- Exit cancel, simultaneous strobes: set mode_cfg 2→1→2 before the boundary → mode never leaves 2 and edge is not reset. Simultaneous read and write rising edges → joy_write and io_read_valid assert in the same cycle.
